// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps an 8:1 mux select, samples y per channel, hands the word downstream.
// Optional: SCAN_AUTO_RESTART_EN makes a completed transfer start the next scan immediately.
module mux_scan_sequencer #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              y_in,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [N_CH-1:0]   dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SEL_W-1:0]   r_sel;
    logic [7:0]         r_cnt;
    logic [N_CH-1:0]    r_cap;
    logic [N_CH-1:0]    r_dout;
    logic               r_valid;
    logic [N_CH-1:0]    w_cap_next;
    logic               w_last_dwell;
    logic               w_last_ch;
    logic               w_xfer;

    assign w_last_dwell = (r_cnt == 8'(DWELL - 1));
    assign w_last_ch    = (r_sel == SEL_W'(N_CH - 1));
    assign w_xfer       = r_valid & dout_ready;

    // The final channel's bit must reach dout on the same edge it is sampled.
    always_comb begin
        w_cap_next        = r_cap;
        w_cap_next[r_sel] = y_in;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && !abort) w_next = S_SCAN;
            S_SCAN: begin
                if (abort)                         w_next = S_IDLE;
                else if (w_last_dwell && w_last_ch) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (abort) w_next = S_IDLE;
`ifdef SCAN_AUTO_RESTART_EN
                else if (w_xfer) w_next = S_SCAN;
`else
                else if (w_xfer) w_next = S_IDLE;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_cap   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_SCAN) begin
                        r_sel <= '0;
                        r_cnt <= '0;
                        r_cap <= '0;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        r_sel <= '0;
                        r_cnt <= '0;
                    end else if (w_last_dwell) begin
                        r_cap <= w_cap_next;
                        r_cnt <= '0;
                        if (w_last_ch) begin
                            r_dout  <= w_cap_next;
                            r_valid <= 1'b1;
                        end else begin
                            r_sel <= r_sel + SEL_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (abort || w_xfer) begin
                        r_valid <= 1'b0;
                        r_sel   <= '0;
                        r_cnt   <= '0;
                        r_cap   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel        = r_sel;
    assign busy       = (r_state != S_IDLE);
    assign dout       = r_dout;
    assign dout_valid = r_valid;

endmodule
